// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

  // Request FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } lsu_state_e;

  // funct3 encodings for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2
  } lsu_size_e;

  // Access size; unlisted encodings fall back to a word access
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SzByte;
      F3_H, F3_HU: return SzHalf;
      default:     return SzWord;
    endcase
  endfunction

  // Byte enables; low address bits that do not fit the size are ignored
  function automatic logic [3:0] gen_be(input lsu_size_e size, input logic [1:0] lo);
    case (size)
      SzByte:  return 4'b0001 << lo;
      SzHalf:  return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane the access could land in
  function automatic logic [31:0] gen_wdata(input lsu_size_e size, input logic [31:0] wdata);
    case (size)
      SzByte:  return {4{wdata[7:0]}};
      SzHalf:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the byte/half lane and extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select and sign/zero extension
  always_comb begin
    byte_v = 8'h00;
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    ld_value = {{24{byte_v[7]}}, byte_v};
      F3_H:    ld_value = {{16{half_v[15]}}, half_v};
      F3_BU:   ld_value = {24'h000000, byte_v};
      F3_HU:   ld_value = {16'h0000, half_v};
      default: ld_value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one memory request per load/store, stalls until ack.
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently aligning them.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_is_load,
  input  logic              mem_is_store,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              stall,
  output logic              misalign_exc
);

  lsu_state_e  state;
  logic [1:0]  ld_lo_q;
  logic [2:0]  ld_f3_q;
  logic [31:0] ld_fmt;
  logic        op;
  logic        misaligned;
  logic        issue;
  lsu_size_e   size;

  assign op   = mem_valid & (mem_is_load | mem_is_store);
  assign size = f3_size(mem_funct3);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size == SzHalf) && mem_addr[0]) ||
                      ((size == SzWord) && (mem_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign issue = (state == StIdle) & op & ~misaligned;

  // Gated by rst so the pipeline sees no stall/trap while the unit is held in reset
  assign stall        = ~rst & (issue | (state == StReq));
  assign misalign_exc = ~rst & (state == StIdle) & op & misaligned;

  lsu_load_align u_load_align (
    .rdata    (dm_rdata),
    .addr_lo  (ld_lo_q),
    .funct3   (ld_f3_q),
    .ld_value (ld_fmt)
  );

  // Request FSM with registered memory-side outputs and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= 4'b0000;
      dm_wdata <= '0;
      ld_data  <= '0;
      ld_valid <= 1'b0;
      ld_lo_q  <= 2'b00;
      ld_f3_q  <= 3'b000;
    end else begin
      ld_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (issue) begin
            dm_req   <= 1'b1;
            dm_we    <= mem_is_store;
            dm_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
            dm_be    <= gen_be(size, mem_addr[1:0]);
            dm_wdata <= gen_wdata(size, mem_wdata);
            ld_lo_q  <= mem_addr[1:0];
            ld_f3_q  <= mem_funct3;
            state    <= StReq;
          end
        end
        StReq: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (!dm_we) begin
              ld_data  <= ld_fmt;
              ld_valid <= 1'b1;
            end
            state <= StDone;
          end
        end
        StDone: begin
          // Pipeline advances this cycle; never re-issue the same instruction
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
